// File: rtl/div_arbiter_if.sv
// Bundle of requester handshakes, divider operand/result wires and the
// response/status outputs shared between div_arbiter and its environment.
interface div_arbiter_if;
  logic        req_valid0;
  logic [31:0] req_dd0;
  logic [31:0] req_ds0;
  logic        req_ready0;
  logic        req_valid1;
  logic [31:0] req_dd1;
  logic [31:0] req_ds1;
  logic        req_ready1;
  logic [31:0] div_ddp;
  logic [31:0] div_dsp;
  logic [31:0] div_qout;
  logic [31:0] div_rem;
  logic        div_ex;
  logic        resp_valid0;
  logic        resp_valid1;
  logic [31:0] resp_q;
  logic [31:0] resp_rem;
  logic        resp_ex;
  logic        busy;
  logic [7:0]  ex_count;

  modport slave (
    input  req_valid0, req_dd0, req_ds0, req_valid1, req_dd1, req_ds1,
    input  div_qout, div_rem, div_ex,
    output req_ready0, req_ready1, div_ddp, div_dsp,
    output resp_valid0, resp_valid1, resp_q, resp_rem, resp_ex, busy, ex_count
  );

  modport master (
    output req_valid0, req_dd0, req_ds0, req_valid1, req_dd1, req_ds1,
    output div_qout, div_rem, div_ex,
    input  req_ready0, req_ready1, div_ddp, div_dsp,
    input  resp_valid0, resp_valid1, resp_q, resp_rem, resp_ex, busy, ex_count
  );
endinterface

// File: rtl/div_arbiter.sv
// Shares one multicycle combinational divider between two requesters.
// Operands are registered and held LATENCY cycles before the divider result
// is captured; the owner then gets a one-cycle response pulse. A zero
// divisor short-circuits to an exception response without using the divider.
module div_arbiter #(
  parameter int unsigned LATENCY = 4  // legal range 1..15
) (
  input  logic          clock,
  input  logic          reset,
  div_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic [31:0] ddp_q, ddp_d;
  logic [31:0] dsp_q, dsp_d;
  logic [31:0] q_q, q_d;
  logic [31:0] rem_q, rem_d;
  logic        ex_q, ex_d;
  logic [7:0]  exc_q, exc_d;

  logic        grant0_s, grant1_s;
  logic [31:0] sel_dd_s, sel_ds_s;

  // Saturating increment for the exception counter: sticks at 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Round-robin grant in IDLE: on contention the requester that did not win last time goes.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_q == IDLE) begin
      if (bus.req_valid0 && bus.req_valid1) begin
        grant0_s = last_grant_q;
        grant1_s = !last_grant_q;
      end else begin
        grant0_s = bus.req_valid0;
        grant1_s = bus.req_valid1;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Operand selection for whichever requester is being accepted this cycle.
  always_comb begin
    sel_dd_s = 32'd0;
    sel_ds_s = 32'd0;
    if (grant1_s) begin
      sel_dd_s = bus.req_dd1;
      sel_ds_s = bus.req_ds1;
    end else begin
      sel_dd_s = bus.req_dd0;
      sel_ds_s = bus.req_ds0;
    end
  end

  // Next-state and datapath update for the IDLE/WAIT/RESP sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    ddp_d        = ddp_q;
    dsp_d        = dsp_q;
    q_d          = q_q;
    rem_d        = rem_q;
    ex_d         = ex_q;
    exc_d        = exc_q;
    case (state_q)
      IDLE: begin
        if (grant0_s || grant1_s) begin
          ddp_d        = sel_dd_s;
          dsp_d        = sel_ds_s;
          owner_d      = grant1_s;
          last_grant_d = grant1_s;
          if (sel_ds_s == 32'd0) begin
            q_d     = 32'd0;
            rem_d   = 32'd0;
            ex_d    = 1'b1;
            exc_d   = sat_inc(exc_q);
            state_d = RESP;
          end else begin
            cnt_d   = 4'(LATENCY);
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          q_d     = bus.div_qout;
          rem_d   = bus.div_rem;
          ex_d    = bus.div_ex;
          if (bus.div_ex) begin
            exc_d = sat_inc(exc_q);
          end else begin
            exc_d = exc_q;
          end
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      ddp_q        <= 32'd0;
      dsp_q        <= 32'd0;
      q_q          <= 32'd0;
      rem_q        <= 32'd0;
      ex_q         <= 1'b0;
      exc_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      ddp_q        <= ddp_d;
      dsp_q        <= dsp_d;
      q_q          <= q_d;
      rem_q        <= rem_d;
      ex_q         <= ex_d;
      exc_q        <= exc_d;
    end
  end

  assign bus.req_ready0  = grant0_s;
  assign bus.req_ready1  = grant1_s;
  assign bus.div_ddp     = ddp_q;
  assign bus.div_dsp     = dsp_q;
  assign bus.resp_valid0 = (state_q == RESP) && !owner_q;
  assign bus.resp_valid1 = (state_q == RESP) && owner_q;
  assign bus.resp_q      = q_q;
  assign bus.resp_rem    = rem_q;
  assign bus.resp_ex     = ex_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.ex_count    = exc_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter: a timeline reference model predicts
// grants and response contents/cycles; a separate monitor pops and compares.
module tb_div_arbiter;
  localparam int LAT = 4;

  typedef struct {
    bit          owner;
    logic [31:0] dd;
    logic [31:0] ds;
    logic [31:0] q;
    logic [31:0] rem;
    bit          ex;
    logic [7:0]  exc;
    int          due;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  div_arbiter_if bus();

  div_arbiter #(.LATENCY(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  // requester stimulus state
  bit          pend[2];
  logic [31:0] dd_r[2];
  logic [31:0] ds_r[2];
  bit          fault_r[2];
  bit          hs[2];

  // reference model state
  int  next_idle = 0;
  bit  last_g = 1'b1;
  int  ex_model = 0;
  bit  fault_mode = 1'b0;

  // divider stand-in: fault_mode forces an exception result
  assign bus.div_ex   = fault_mode;
  assign bus.div_qout = fault_mode ? 32'hFFFF_FFFF :
                        ((bus.div_dsp == 32'd0) ? 32'd0 : bus.div_ddp / bus.div_dsp);
  assign bus.div_rem  = fault_mode ? 32'hFFFF_FFFF :
                        ((bus.div_dsp == 32'd0) ? 32'd0 : bus.div_ddp % bus.div_dsp);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: predict grants from the timeline and push expected responses.
  always @(negedge clock) begin
    if (!reset) begin
      sb.delete();
      next_idle  = 0;
      last_g     = 1'b1;
      ex_model   = 0;
      fault_mode = 1'b0;
      hs[0]      = 1'b0;
      hs[1]      = 1'b0;
    end else begin
      bit   idle, v0, v1, win, e0, e1;
      exp_t e;
      v0   = bus.req_valid0;
      v1   = bus.req_valid1;
      idle = (cyc >= next_idle);
      win  = (v0 && v1) ? !last_g : v1;
      e0   = idle && (v0 || v1) && !win;
      e1   = idle && (v0 || v1) && win;
      chk("req_ready0", 32'(bus.req_ready0), 32'(e0));
      chk("req_ready1", 32'(bus.req_ready1), 32'(e1));
      chk("busy", 32'(bus.busy), 32'(!idle));
      if (e0 || e1) begin
        e.owner = win;
        e.dd    = dd_r[win];
        e.ds    = ds_r[win];
        if (e.ds == 32'd0) begin
          e.q = 32'd0; e.rem = 32'd0; e.ex = 1'b1;
          if (ex_model < 255) ex_model++;
          e.due = cyc + 1;
        end else if (fault_r[win]) begin
          e.q = 32'hFFFF_FFFF; e.rem = 32'hFFFF_FFFF; e.ex = 1'b1;
          if (ex_model < 255) ex_model++;
          e.due = cyc + LAT + 1;
        end else begin
          e.q = e.dd / e.ds; e.rem = e.dd % e.ds; e.ex = 1'b0;
          e.due = cyc + LAT + 1;
        end
        fault_mode = fault_r[win] && (e.ds != 32'd0);
        e.exc      = 8'(ex_model);
        next_idle  = e.due + 1;
        last_g     = win;
        hs[win]    = 1'b1;
        sb.push_back(e);
      end
    end
  end

  // Monitor: compare each response pulse against the head of the scoreboard.
  always @(negedge clock) begin
    if (reset) begin
      if (bus.resp_valid0 && bus.resp_valid1) begin
        checks++; errors++;
        $display("FAIL resp_both: actual=both valid required=one at cycle %0d", cyc);
      end else if (bus.resp_valid0 || bus.resp_valid1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected: actual=pulse required=none at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_owner", 32'(bus.resp_valid1), 32'(e.owner));
          chk("resp_cycle", 32'(cyc), 32'(e.due));
          chk("resp_q", bus.resp_q, e.q);
          chk("resp_rem", bus.resp_rem, e.rem);
          chk("resp_ex", 32'(bus.resp_ex), 32'(e.ex));
          chk("ex_count", 32'(bus.ex_count), 32'(e.exc));
          chk("div_ddp", bus.div_ddp, e.dd);
          chk("div_dsp", bus.div_dsp, e.ds);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checks++; errors++;
        $display("FAIL resp_missing: actual=no pulse required=pulse due %0d at cycle %0d", sb[0].due, cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic apply();
    bus.req_valid0 = pend[0];
    bus.req_dd0    = dd_r[0];
    bus.req_ds0    = ds_r[0];
    bus.req_valid1 = pend[1];
    bus.req_dd1    = dd_r[1];
    bus.req_ds1    = ds_r[1];
  endtask

  task automatic set_op(input int n, input logic [31:0] dd, input logic [31:0] ds, input bit f);
    pend[n]    = 1'b1;
    dd_r[n]    = dd;
    ds_r[n]    = ds;
    fault_r[n] = f;
    apply();
  endtask

  task automatic tick(input bit rnd);
    @(posedge clock);
    #1;
    for (int n = 0; n < 2; n++) begin
      if (hs[n]) begin
        pend[n] = 1'b0;
        hs[n]   = 1'b0;
      end else if (rnd && pend[n] && $urandom_range(0, 15) == 0) begin
        pend[n] = 1'b0;
      end
      if (rnd && !pend[n] && $urandom_range(0, 3) == 0) begin
        pend[n]    = 1'b1;
        dd_r[n]    = $urandom;
        case ($urandom_range(0, 7))
          0:       ds_r[n] = 32'd0;
          1, 2, 3: ds_r[n] = 32'($urandom_range(1, 16));
          default: ds_r[n] = $urandom;
        endcase
        fault_r[n] = ($urandom_range(0, 7) == 0);
      end
    end
    apply();
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while ((pend[0] || pend[1] || sb.size() != 0) && k < budget) begin
      tick(1'b0);
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL wait_done: actual=timeout after %0d cycles required=completion", budget);
    end
  endtask

  task automatic wait_hs(input int n, input int budget);
    int k = 0;
    while (pend[n] && k < budget) begin
      tick(1'b0);
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL wait_hs: actual=no grant for requester %0d required=grant", n);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    apply();
    tick(1'b0);
    tick(1'b0);
    reset = 1'b1;
  endtask

  task automatic chk_zero();
    chk("rst_div_ddp", bus.div_ddp, 32'd0);
    chk("rst_div_dsp", bus.div_dsp, 32'd0);
    chk("rst_resp_q", bus.resp_q, 32'd0);
    chk("rst_resp_rem", bus.resp_rem, 32'd0);
    chk("rst_resp_ex", 32'(bus.resp_ex), 32'd0);
    chk("rst_ex_count", 32'(bus.ex_count), 32'd0);
    chk("rst_resp_valid", 32'({bus.resp_valid0, bus.resp_valid1}), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=simulation still running required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 2; n++) begin
      pend[n] = 1'b0; dd_r[n] = 32'd0; ds_r[n] = 32'd0; fault_r[n] = 1'b0; hs[n] = 1'b0;
    end
    apply();
    tick(1'b0);
    do_reset();
    chk_zero();

    // contention from reset release, then a third contention
    set_op(0, 32'd20, 32'd4, 1'b0);
    set_op(1, 32'd81, 32'd9, 1'b0);
    wait_done(40);
    set_op(0, 32'd30, 32'd6, 1'b0);
    set_op(1, 32'd49, 32'd7, 1'b0);
    wait_done(40);
    set_op(0, 32'd8, 32'd2, 1'b0);
    set_op(1, 32'd9, 32'd3, 1'b0);
    wait_done(40);

    // single requester, basic division
    set_op(0, 32'd100, 32'd7, 1'b0);
    wait_done(20);

    // zero divisor from requester 1
    set_op(1, 32'd55, 32'd0, 1'b0);
    wait_done(20);
    chk("ex_count_after_zero", 32'(bus.ex_count), 32'd1);

    // requester 0 raised and withdrawn during requester 1 WAIT
    set_op(1, 32'd500, 32'd7, 1'b0);
    wait_hs(1, 20);
    set_op(0, 32'd9, 32'd3, 1'b0);
    tick(1'b0);
    tick(1'b0);
    pend[0] = 1'b0;
    apply();
    wait_done(20);

    // reset two cycles into WAIT, then a clean operation
    set_op(0, 32'd1000, 32'd3, 1'b0);
    wait_hs(0, 20);
    tick(1'b0);
    do_reset();
    chk_zero();
    set_op(1, 32'd77, 32'd5, 1'b0);
    wait_done(20);

    // saturate the exception counter
    for (int i = 0; i < 256; i++) begin
      set_op(0, 32'(i), 32'd0, 1'b0);
      wait_done(20);
    end
    chk("ex_count_saturated", 32'(bus.ex_count), 32'd255);
    set_op(1, 32'd1, 32'd0, 1'b0);
    wait_done(20);
    chk("ex_count_hold", 32'(bus.ex_count), 32'd255);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick(1'b1);
    end
    wait_done(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Sequences and shares the single 32-bit divider between two requesters: requester 0 is the processor execute stage and requester 1 is the guidance calculation unit.
- The divider is a long combinational path and is treated as a multicycle path.
- This block holds the divider operands in registers for LATENCY cycles, then captures quotient, remainder and exception.
- It returns the result to the owning requester with a one-cycle pulse.

Parameters:
- LATENCY, 4, cycles the operands are held before the result is captured; legal range 1..15.

Ports:
- clock  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-low reset
- req_valid0  in  1  requester 0 has an operation pending
- req_dd0  in  32  requester 0 dividend
- req_ds0  in  32  requester 0 divisor
- req_ready0  out  1  handshake accept for requester 0
- req_valid1  in  1  requester 1 has an operation pending
- req_dd1  in  32  requester 1 dividend
- req_ds1  in  32  requester 1 divisor
- req_ready1  out  1  handshake accept for requester 1
- div_ddp  out  32  registered dividend to the divider
- div_dsp  out  32  registered divisor to the divider
- div_qout  in  32  divider quotient
- div_rem  in  32  divider remainder
- div_ex  in  1  divider divide-by-zero flag
- resp_valid0  out  1  one-cycle result pulse to requester 0
- resp_valid1  out  1  one-cycle result pulse to requester 1
- resp_q  out  32  captured quotient
- resp_rem  out  32  captured remainder
- resp_ex  out  1  captured exception
- busy  out  1  high whenever state is not IDLE
- ex_count  out  8  saturating count of divide-by-zero operations

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - Every output register clears to 0: div_ddp, div_dsp, resp_*, ex_count.
  - The wait counter clears to 0 and last_grant is set to 1, so requester 0 wins first.
  - Reset mid-operation drops the transaction silently; no resp_valid is issued.
- States: IDLE, WAIT, RESP.
- IDLE, arbitration:
  - grant = round-robin among asserted req_valid.
  - On a tie the winner is the requester not equal to last_grant.
  - With a single requester, that requester wins.
- IDLE, handshake:
  - req_readyN = (state==IDLE) && grantN; this is combinational and at most one is high.
  - A handshake is req_validN && req_readyN in the same cycle.
  - On handshake: latch req_ddN/req_dsN into div_ddp/div_dsp, record owner=N, and set last_grant=N.
  - If req_dsN != 0: load counter=LATENCY and go to WAIT.
  - If req_dsN == 0: go straight to RESP with resp_q=0, resp_rem=0, resp_ex=1. The divider is not waited on, and ex_count increments unless it is at 255.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle counter==1, capture div_qout/div_rem/div_ex into resp_q/resp_rem/resp_ex and go to RESP.
  - If the captured div_ex==1, ex_count saturating-increments.
- RESP:
  - resp_valid[owner]=1 for exactly one cycle, then go to IDLE.
  - No new handshake is accepted in RESP.
- Latency:
  - Nonzero divisor, handshake at cycle T: resp_valid at T+LATENCY+1.
  - Zero divisor: resp_valid at T+1.
  - Minimum issue interval is LATENCY+2 cycles (LATENCY=4 gives 6).
- Holding rules:
  - div_ddp/div_dsp hold stable from handshake until the next handshake.
  - resp_q/resp_rem/resp_ex hold until the next capture.
- Requester rules:
  - A requester must keep its operands stable while req_valid is high and it has not yet been granted.
  - It may drop req_valid before being granted; that is a withdrawal with no side effects.
  - req_valid seen during WAIT or RESP is ignored; no ready is given.
- Responses are never back-pressured. Requesters must be able to accept resp_valid in any cycle.
- ex_count saturates at 255 and never wraps.

Test Plan:
- LATENCY=4, only req_valid0 with dd=100, ds=7, handshake at T -> busy high T+1..T+5; resp_valid0 at T+5; resp_q=14, resp_rem=2, resp_ex=0; resp_valid1 stays 0.
- Both requesters valid from reset release (req0 20/4, req1 81/9) -> req0 granted first (q=5); req1 granted in the IDLE cycle after req0's RESP (q=9); a third contention grants req0 again.
- req_valid1 with ds=0, dd=55 -> resp_valid1 exactly one cycle after the handshake; resp_q=0, resp_rem=0, resp_ex=1; ex_count 0->1.
- Reset driven low two cycles into WAIT -> no resp_valid; all outputs 0; the next request completes normally with correct latency.
- 256 back-to-back zero-divisor ops -> ex_count reaches 255 and holds.
- req_valid0 raised during WAIT of a req1 op, then dropped before RESP -> req_ready0 never asserts; no response to requester 0.
